// File: rtl/sprite_pkg.sv
// Shared types and field positions for the sprite fetch sequencer and its slot load bus.
package sprite_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } state_t;

    typedef enum logic [2:0] {
        STEP_ADDR_Y,
        STEP_CAP_Y,
        STEP_CAP_TILE,
        STEP_CAP_ATTR,
        STEP_CAP_X,
        STEP_PIX1,
        STEP_RD_HI,
        STEP_PIX2
    } step_t;

    // Per-slot load strobe bit indices
    localparam int unsigned LD_PIX1 = 3;
    localparam int unsigned LD_PIX2 = 2;
    localparam int unsigned LD_X    = 1;
    localparam int unsigned LD_ATTR = 0;

    // Shared load bus layout {pix1, pix2, x, color, prio}
    localparam int unsigned LI_W     = 27;
    localparam int unsigned LI_PIX1  = 19;
    localparam int unsigned LI_PIX2  = 11;
    localparam int unsigned LI_X     = 3;
    localparam int unsigned LI_COLOR = 1;
    localparam int unsigned LI_PRIO  = 0;

    localparam int unsigned ATTR_VFLIP = 7;
    localparam int unsigned ATTR_HFLIP = 6;
    localparam int unsigned ATTR_PRIO  = 5;

    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        return {<<{d}};
    endfunction

    function automatic logic [31:0] slot_strobe(input logic [2:0] slot, input int unsigned ld_bit);
        return 32'd1 << ({slot, 2'b00} | 5'(ld_bit));
    endfunction

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// Memory and slot-bank bus between the fetch sequencer (master) and OAM/VRAM/slots (slave).
interface sprite_fetch_ctrl_if;
    import sprite_pkg::*;

    logic [4:0]      oam_addr;
    logic [7:0]      oam_data;
    logic            pat_rd;
    logic [12:0]     pat_addr;
    logic [7:0]      vram_data;
    logic [31:0]     slot_load;
    logic [LI_W-1:0] slot_load_in;
    logic [39:0]     slot_bits;

    modport master (
        output oam_addr, pat_rd, pat_addr, slot_load, slot_load_in,
        input  oam_data, vram_data, slot_bits
    );

    modport slave (
        input  oam_addr, pat_rd, pat_addr, slot_load, slot_load_in,
        output oam_data, vram_data, slot_bits
    );

endinterface

// File: rtl/sprite_prio_mux.sv
// Picks the lowest-index slot with a non-transparent pixel; reports whether slot 0 won.
module sprite_prio_mux (
    input  logic [39:0] slot_bits,
    output logic [4:0]  pixel,
    output logic        slot0_win
);

    logic found;

    always_comb begin
        pixel = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && (slot_bits[5*i +: 2] != 2'b00)) begin
                pixel = slot_bits[5*i +: 5];
                found = 1'b1;
            end
        end
        slot0_win = (slot_bits[1:0] != 2'b00);
    end

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// HBlank sprite fetch sequencer: reads secondary OAM, fetches both pattern planes per slot
// and strobes the results into the 8 sprite slots; also resolves the slots' pixel priority.
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic                       start,
    input  logic [3:0]                 sprite_count,
    input  logic                       sprite0_in,
    input  logic [7:0]                 scanline,
    input  logic                       obj_size16,
    input  logic                       obj_table,
    sprite_fetch_ctrl_if.master        bus,
    output logic [4:0]                 spr_pixel,
    output logic                       spr0_opaque,
    output logic                       busy,
    output logic                       done
);

    state_t      state;
    step_t       step;
    logic [2:0]  slot;
    logic [7:0]  spr_y;
    logic [7:0]  spr_tile;
    logic [7:0]  spr_attr;
    logic        sprite0_flag;

    logic        slot_valid;
    logic [7:0]  row_raw;
    logic [7:0]  row;
    logic [12:0] pat_base;
    logic [7:0]  pix_data;
    logic        slot0_win;

    assign slot_valid = ({1'b0, slot} < sprite_count);
    assign row_raw    = scanline - spr_y;

    always_comb begin
        row = row_raw;
        if (spr_attr[ATTR_VFLIP]) begin
            row = row_raw ^ (obj_size16 ? 8'h0F : 8'h07);
        end
    end

    // Plane select is bit 3 in both layouts; pat_base is the low plane.
    assign pat_base = obj_size16 ? {spr_tile[0], spr_tile[7:1], row[3], 1'b0, row[2:0]}
                                 : {obj_table, spr_tile, 1'b0, row[2:0]};

    always_comb begin
        pix_data = '0;
        if (slot_valid) begin
            pix_data = spr_attr[ATTR_HFLIP] ? bus.vram_data : bit_rev8(bus.vram_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            step             <= STEP_ADDR_Y;
            slot             <= '0;
            spr_y            <= '0;
            spr_tile         <= '0;
            spr_attr         <= '0;
            sprite0_flag     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.oam_addr     <= '0;
            bus.pat_rd       <= 1'b0;
            bus.pat_addr     <= '0;
            bus.slot_load    <= '0;
            bus.slot_load_in <= '0;
        end else if (ce) begin
            done             <= 1'b0;
            bus.pat_rd       <= 1'b0;
            bus.slot_load    <= '0;
            bus.slot_load_in <= '0;
            if (start) begin
                state        <= ST_FETCH;
                step         <= STEP_ADDR_Y;
                slot         <= '0;
                busy         <= 1'b1;
                sprite0_flag <= sprite0_in;
            end else if (state == ST_FETCH) begin
                case (step)
                    STEP_ADDR_Y: begin
                        bus.oam_addr <= {slot, 2'd0};
                    end
                    STEP_CAP_Y: begin
                        spr_y        <= bus.oam_data;
                        bus.oam_addr <= {slot, 2'd1};
                    end
                    STEP_CAP_TILE: begin
                        spr_tile     <= bus.oam_data;
                        bus.oam_addr <= {slot, 2'd2};
                    end
                    STEP_CAP_ATTR: begin
                        spr_attr      <= bus.oam_data;
                        bus.oam_addr  <= {slot, 2'd3};
                        bus.slot_load <= slot_strobe(slot, LD_ATTR);
                        if (slot_valid) begin
                            bus.slot_load_in[LI_COLOR +: 2] <= bus.oam_data[1:0];
                            bus.slot_load_in[LI_PRIO]       <= bus.oam_data[ATTR_PRIO];
                        end
                    end
                    STEP_CAP_X: begin
                        bus.slot_load               <= slot_strobe(slot, LD_X);
                        bus.slot_load_in[LI_X +: 8] <= slot_valid ? bus.oam_data : 8'hFF;
                        bus.pat_rd                  <= 1'b1;
                        bus.pat_addr                <= pat_base;
                    end
                    STEP_PIX1: begin
                        bus.slot_load                  <= slot_strobe(slot, LD_PIX1);
                        bus.slot_load_in[LI_PIX1 +: 8] <= pix_data;
                    end
                    STEP_RD_HI: begin
                        bus.pat_rd   <= 1'b1;
                        bus.pat_addr <= pat_base | 13'h0008;
                    end
                    STEP_PIX2: begin
                        bus.slot_load                  <= slot_strobe(slot, LD_PIX2);
                        bus.slot_load_in[LI_PIX2 +: 8] <= pix_data;
                    end
                    default: ;
                endcase

                step <= step_t'(step + 3'd1);
                if (step == STEP_PIX2) begin
                    if (slot == 3'(NUM_SLOTS - 1)) begin
                        state <= ST_IDLE;
                        slot  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
            end
        end
    end

    sprite_prio_mux u_prio_mux (
        .slot_bits (bus.slot_bits),
        .pixel     (spr_pixel),
        .slot0_win (slot0_win)
    );

    assign spr0_opaque = sprite0_flag && slot0_win;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Randomized bench for sprite_fetch_ctrl against a per-slot arithmetic reference model.
module tb_sprite_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, ce, start;
    logic [3:0]  sprite_count;
    logic        sprite0_in;
    logic [7:0]  scanline;
    logic        obj_size16, obj_table;
    logic [4:0]  spr_pixel;
    logic        spr0_opaque, busy, done;
    logic [39:0] slot_bits;
    logic [7:0]  oam  [32];
    logic [7:0]  vram [8192];

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          flag_m = 1'b0;

    always #5 clk = ~clk;

    sprite_fetch_ctrl_if bus();

    assign bus.oam_data  = oam[bus.oam_addr];
    assign bus.vram_data = vram[bus.pat_addr];
    assign bus.slot_bits = slot_bits;

    sprite_fetch_ctrl #(.NUM_SLOTS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .start        (start),
        .sprite_count (sprite_count),
        .sprite0_in   (sprite0_in),
        .scanline     (scanline),
        .obj_size16   (obj_size16),
        .obj_table    (obj_table),
        .bus          (bus),
        .spr_pixel    (spr_pixel),
        .spr0_opaque  (spr0_opaque),
        .busy         (busy),
        .done         (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_addr(input int unsigned s, input int unsigned plane);
        int unsigned y, tile, attr, row;
        y    = oam[4*s];
        tile = oam[4*s+1];
        attr = oam[4*s+2];
        row  = (256 + scanline - y) % 256;
        if (attr & 128) row = row ^ (obj_size16 ? 15 : 7);
        if (!obj_size16)
            return obj_table * 4096 + tile * 16 + plane * 8 + row % 8;
        return (tile % 2) * 4096 + (tile / 2) * 32 + ((row / 8) % 2) * 16 + plane * 8 + row % 8;
    endfunction

    function automatic int unsigned ref_pix(input int unsigned s, input int unsigned plane);
        int unsigned b, attr, r;
        if (s >= sprite_count) return 0;
        b    = vram[ref_addr(s, plane)];
        attr = oam[4*s+2];
        if (attr & 64) return b;
        r = 0;
        for (int i = 0; i < 8; i++)
            if ((b >> i) & 1) r = r | (1 << (7 - i));
        return r;
    endfunction

    // k = number of ce-qualified edges since the start edge
    task automatic check_outputs(input int unsigned k);
        int unsigned s, st, attr, exp_load, exp_rd;
        bit valid;
        if (k == 0) begin
            check_val("start_busy", busy, 1);
            check_val("start_done", done, 0);
            check_val("start_load", bus.slot_load, 0);
            check_val("start_rd", bus.pat_rd, 0);
            return;
        end
        s        = (k - 1) / 8;
        st       = (k - 1) % 8;
        valid    = s < sprite_count;
        attr     = oam[4*s+2];
        exp_load = 0;
        exp_rd   = 0;
        case (st)
            3: begin
                exp_load = 1 << (4*s);
                check_val("ld_attr", bus.slot_load_in[2:0],
                          valid ? (((attr & 3) << 1) | ((attr >> 5) & 1)) : 0);
            end
            4: begin
                exp_load = 2 << (4*s);
                exp_rd   = 1;
                check_val("ld_x", bus.slot_load_in[10:3], valid ? oam[4*s+3] : 8'hFF);
                check_val("pat_lo", bus.pat_addr, ref_addr(s, 0));
            end
            5: begin
                exp_load = 8 << (4*s);
                check_val("ld_pix1", bus.slot_load_in[26:19], ref_pix(s, 0));
            end
            6: begin
                exp_rd = 1;
                check_val("pat_hi", bus.pat_addr, ref_addr(s, 1));
            end
            7: begin
                exp_load = 4 << (4*s);
                check_val("ld_pix2", bus.slot_load_in[18:11], ref_pix(s, 1));
            end
            default: ;
        endcase
        if (st <= 3) check_val("oam_addr", bus.oam_addr, 4*s + st);
        check_val("slot_load", bus.slot_load, exp_load);
        check_val("pat_rd", bus.pat_rd, exp_rd);
        check_val("busy", busy, (k < 64) ? 1 : 0);
        check_val("done", done, (k == 64) ? 1 : 0);
    endtask

    task automatic tick(input logic ce_v);
        @(negedge clk);
        ce = ce_v;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        ce    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        flag_m = sprite0_in;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        ce    = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        flag_m = 1'b0;
    endtask

    // mode: 0 ce always on, 1 ce alternating, 2 ce random
    task automatic fetch_run(input int unsigned mode, input int unsigned restart_at,
                             input int unsigned reset_at);
        int unsigned k, cyc;
        bit restarted;
        logic ce_v;
        k = 0;
        cyc = 0;
        restarted = 1'b0;
        start_pulse();
        check_outputs(0);
        while (k < 64 && cyc < 2000) begin
            cyc++;
            if (restart_at != 0 && k == restart_at && !restarted) begin
                restarted = 1'b1;
                start_pulse();
                k = 0;
                check_outputs(0);
                continue;
            end
            if (reset_at != 0 && k == reset_at) begin
                apply_reset();
                check_val("rst_busy", busy, 0);
                check_val("rst_done", done, 0);
                check_val("rst_load", bus.slot_load, 0);
                check_val("rst_rd", bus.pat_rd, 0);
                repeat (72) begin
                    tick(1'b1);
                    check_val("post_rst_load", bus.slot_load, 0);
                    check_val("post_rst_busy", busy, 0);
                    check_val("post_rst_done", done, 0);
                end
                return;
            end
            case (mode)
                0:       ce_v = 1'b1;
                1:       ce_v = (cyc % 2 == 1);
                default: ce_v = ($urandom_range(0, 3) != 0);
            endcase
            tick(ce_v);
            if (ce_v) k++;
            check_outputs(k);
        end
        check_val("timeout", k, 64);
        tick(1'b1);
        check_val("end_done", done, 0);
        check_val("end_busy", busy, 0);
        check_val("end_load", bus.slot_load, 0);
    endtask

    task automatic random_config();
        sprite_count = 4'($urandom_range(0, 8));
        scanline     = 8'($urandom);
        obj_size16   = 1'($urandom);
        obj_table    = 1'($urandom);
        sprite0_in   = 1'($urandom);
        for (int i = 0; i < 32; i++) oam[i] = 8'($urandom);
    endtask

    task automatic check_mux();
        int unsigned exp_pix;
        int win;
        exp_pix = 0;
        win = -1;
        for (int i = 0; i < 8; i++) begin
            if (((slot_bits >> (5*i)) & 3) != 0 && win < 0) begin
                win = i;
                exp_pix = 32'((slot_bits >> (5*i)) & 31);
            end
        end
        check_val("spr_pixel", spr_pixel, exp_pix);
        check_val("spr0_opaque", spr0_opaque, (flag_m && win == 0) ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) oam[i] = 8'($urandom);
        reset = 1'b1; ce = 1'b0; start = 1'b0;
        sprite_count = 4'd0; sprite0_in = 1'b0; scanline = 8'd0;
        obj_size16 = 1'b0; obj_table = 1'b0; slot_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy0", busy, 0);
        check_val("rst_done0", done, 0);
        check_val("rst_load0", bus.slot_load, 0);
        check_val("rst_loadin0", bus.slot_load_in, 0);
        check_val("rst_rd0", bus.pat_rd, 0);
        check_val("rst_paddr0", bus.pat_addr, 0);
        check_val("rst_oaddr0", bus.oam_addr, 0);
        reset = 1'b0;

        // 8x8, row 2, no flip, then same sprite with hflip set
        sprite_count = 4'd2; scanline = 8'd20; obj_size16 = 1'b0; obj_table = 1'b0; sprite0_in = 1'b1;
        oam[0] = 8'd18; oam[1] = 8'h42; oam[2] = 8'h01; oam[3] = 8'h30;
        vram[13'h0422] = 8'h01;
        fetch_run(0, 0, 0);
        oam[2] = 8'h41;
        fetch_run(0, 0, 0);

        // 8x16 with vertical flip, row 9
        obj_size16 = 1'b1;
        oam[0] = 8'd11; oam[1] = 8'h43; oam[2] = 8'h80; oam[3] = 8'h55;
        fetch_run(0, 0, 0);

        sprite_count = 4'd0;
        fetch_run(0, 0, 0);

        random_config();
        fetch_run(1, 0, 0);
        random_config();
        fetch_run(0, 30, 0);
        random_config();
        fetch_run(2, 0, 29);
        repeat (6) begin
            random_config();
            fetch_run(2, 0, 0);
        end

        sprite0_in = 1'b1;
        fetch_run(0, 0, 0);
        slot_bits = '0;
        slot_bits[14:10] = 5'b00011;
        slot_bits[29:25] = 5'b10001;
        #1 check_mux();
        slot_bits[4:0] = 5'b01010;
        #1 check_mux();
        repeat (20) begin
            for (int i = 0; i < 8; i++) begin
                slot_bits[5*i +: 5] = 5'($urandom);
                if ($urandom_range(0, 1) == 0) slot_bits[5*i +: 2] = 2'b00;
            end
            #1 check_mux();
        end
        apply_reset();
        slot_bits[4:0] = 5'b00001;
        #1 check_mux();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
